lcd_bus_responder: RTL

- Synthesizable HD44780-compatible responder: the device end of the 8-bit parallel LCD bus (`lcd_e`, `lcd_rs`, `lcd_rw`, 8-bit data) that our LCD driver controls.
- Decodes instructions and data writes, maintains an 80-byte single-line DDRAM, an address counter (AC) and display flags.
- Models the busy flag (BF) with cycle-accurate busy times.
- Used as an on-chip LCD stand-in for self-test and as the DUT-side model in driver regressions.

---
 rtl/lcd_pkg.sv | 64 ++++++
 rtl/lcd_bus_sync.sv | 38 +++
 rtl/lcd_bus_responder.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared types, opcode classes and wrap helper for the HD44780-style LCD bus responder.
package lcd_pkg;

  localparam int         DDRAM_SIZE = 80;
  localparam logic [7:0] LCD_SPACE  = 8'h20;

  typedef enum logic [3:0] {
    OP_NOP,
    OP_CLEAR,
    OP_HOME,
    OP_ENTRY,
    OP_DISP,
    OP_SHIFT,
    OP_FUNC,
    OP_CGRAM,
    OP_DDRAM
  } op_class_t;

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } state_t;

  typedef struct packed {
    logic       rs;
    logic       rw;
    logic [7:0] dat;
  } bus_smp_t;

  typedef struct packed {
    logic disp_on;
    logic cursor_on;
    logic blink_on;
    logic dl_8bit;
    logic n_2line;
    logic f_5x10;
    logic inc;
    logic shift_en;
    logic cg_sel;
  } flags_t;

  localparam flags_t FLAGS_RST = '{dl_8bit: 1'b1, inc: 1'b1, default: 1'b0};

  // Instruction class is selected by the highest set bit of the command byte.
  function automatic op_class_t decode_op(input logic [7:0] d);
    if (d[7])      return OP_DDRAM;
    else if (d[6]) return OP_CGRAM;
    else if (d[5]) return OP_FUNC;
    else if (d[4]) return OP_SHIFT;
    else if (d[3]) return OP_DISP;
    else if (d[2]) return OP_ENTRY;
    else if (d[1]) return OP_HOME;
    else if (d[0]) return OP_CLEAR;
    else           return OP_NOP;
  endfunction

  function automatic logic [6:0] wrap_step(input logic [6:0] v, input logic up, input int size);
    logic [6:0] top_addr;
    top_addr = 7'(size - 1);
    if (up) return (v >= top_addr) ? 7'd0 : v + 7'd1;
    else    return (v == 7'd0) ? top_addr : v - 7'd1;
  endfunction

endpackage

// File: rtl/lcd_bus_sync.sv
// Two-flop synchronizer for {e, rs, rw, data} plus E edge detect; strobe fires 2 clk after pin E changes.
// No backpressure: the bus is sampled every cycle and the driver owns the timing.
module lcd_bus_sync
  import lcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       lcd_e,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic [7:0] data_in,
  output bus_smp_t   smp,
  output logic       e_sync,
  output logic       rise,
  output logic       fall
);

  // {e, rs, rw, data}; s3 is the edge-history stage, so on a fall it still holds the last E-high sample
  logic [10:0] s1, s2, s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= {lcd_e, lcd_rs, lcd_rw, data_in};
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign smp    = bus_smp_t'(s3[9:0]);
  assign e_sync = s3[10];
  assign rise   = s2[10] & ~s3[10];
  assign fall   = ~s2[10] & s3[10];

endmodule

// File: rtl/lcd_bus_responder.sv
// HD44780-compatible LCD bus device: executes write strobes the cycle after detection, then holds BF for BUSY_*_CYC clk.
// Writes arriving while busy are dropped with a cmd_drop pulse; reads only with LCD_RESP_READ_EN defined.
module lcd_bus_responder #(
  parameter int BUSY_SHORT_CYC = 3700,
  parameter int BUSY_LONG_CYC  = 152000,
  parameter int DDRAM_SIZE     = 80
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lcd_e,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic       busy,
  output logic [6:0] ac,
  output logic       disp_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       dl_8bit,
  output logic       n_2line,
  output logic       f_5x10,
  output logic       inc,
  output logic       shift_en,
  output logic [6:0] shift_ofs,
  output logic       cg_sel,
  output logic       cmd_drop,
  input  logic [6:0] dbg_addr,
  output logic [7:0] dbg_data
);

  import lcd_pkg::*;

  localparam int               CNT_W     = $clog2(BUSY_LONG_CYC + 1);
  localparam logic [CNT_W-1:0] SHORT_LD  = CNT_W'(BUSY_SHORT_CYC - 1);
  localparam logic [CNT_W-1:0] LONG_LD   = CNT_W'(BUSY_LONG_CYC - 1);
  localparam logic [6:0]       ADDR_SPAN = 7'(DDRAM_SIZE);

  bus_smp_t         smp;
  logic             e_sync, bus_rise, bus_fall;
  logic             wr_stb, rd_stb;
  op_class_t        op;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [6:0]       ac_q, ac_d, ofs_q, ofs_d;
  flags_t           flg_q, flg_d;
  logic             drop_q, drop_d;
  logic             mem_we, mem_clr;
  logic [7:0]       ddram [DDRAM_SIZE];

  lcd_bus_sync u_sync (
    .clk     (clk),
    .rst     (rst),
    .lcd_e   (lcd_e),
    .lcd_rs  (lcd_rs),
    .lcd_rw  (lcd_rw),
    .data_in (data_in),
    .smp     (smp),
    .e_sync  (e_sync),
    .rise    (bus_rise),
    .fall    (bus_fall)
  );

  assign wr_stb = bus_fall & ~smp.rw;
  assign rd_stb = bus_fall & smp.rw;
  assign op     = decode_op(smp.dat);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ac_d    = ac_q;
    ofs_d   = ofs_q;
    flg_d   = flg_q;
    drop_d  = 1'b0;
    mem_we  = 1'b0;
    mem_clr = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (wr_stb) begin
          state_d = ST_BUSY;
          cnt_d   = SHORT_LD;
          if (smp.rs) begin
            mem_we = ~flg_q.cg_sel;
            ac_d   = wrap_step(ac_q, flg_q.inc, DDRAM_SIZE);
            if (flg_q.shift_en) ofs_d = wrap_step(ofs_q, flg_q.inc, DDRAM_SIZE);
          end else begin
            case (op)
              OP_CLEAR: begin
                mem_clr      = 1'b1;
                ac_d         = 7'd0;
                ofs_d        = 7'd0;
                flg_d.inc    = 1'b1;
                flg_d.cg_sel = 1'b0;
                cnt_d        = LONG_LD;
              end
              OP_HOME: begin
                ac_d  = 7'd0;
                ofs_d = 7'd0;
                cnt_d = LONG_LD;
              end
              OP_ENTRY: begin
                flg_d.inc      = smp.dat[1];
                flg_d.shift_en = smp.dat[0];
              end
              OP_DISP: begin
                flg_d.disp_on   = smp.dat[2];
                flg_d.cursor_on = smp.dat[1];
                flg_d.blink_on  = smp.dat[0];
              end
              // Display shift right (bit2=1) lowers the offset; cursor shift right raises AC
              OP_SHIFT: begin
                if (smp.dat[3]) ofs_d = wrap_step(ofs_q, ~smp.dat[2], DDRAM_SIZE);
                else            ac_d  = wrap_step(ac_q, smp.dat[2], DDRAM_SIZE);
              end
              OP_FUNC: begin
                flg_d.dl_8bit = smp.dat[4];
                flg_d.n_2line = smp.dat[3];
                flg_d.f_5x10  = smp.dat[2];
              end
              OP_CGRAM: flg_d.cg_sel = 1'b1;
              OP_DDRAM: begin
                flg_d.cg_sel = 1'b0;
                ac_d = (smp.dat[6:0] >= ADDR_SPAN) ? smp.dat[6:0] - ADDR_SPAN : smp.dat[6:0];
              end
              default: ;
            endcase
          end
        end
      end
      ST_BUSY: begin
        drop_d = wr_stb;
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef LCD_RESP_READ_EN
    if (rd_stb && smp.rs) ac_d = wrap_step(ac_q, flg_q.inc, DDRAM_SIZE);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ac_q    <= '0;
      ofs_q   <= '0;
      flg_q   <= FLAGS_RST;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ac_q    <= ac_d;
      ofs_q   <= ofs_d;
      flg_q   <= flg_d;
      drop_q  <= drop_d;
    end
  end

  // Flop-based DDRAM so Clear can rewrite every byte in a single cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DDRAM_SIZE; i++) ddram[i] <= LCD_SPACE;
    end else if (mem_clr) begin
      for (int i = 0; i < DDRAM_SIZE; i++) ddram[i] <= LCD_SPACE;
    end else if (mem_we) begin
      ddram[ac_q] <= smp.dat;
    end
  end

  assign dbg_data = (dbg_addr < ADDR_SPAN) ? ddram[dbg_addr] : 8'h00;

`ifdef LCD_RESP_READ_EN
  logic [7:0] rd_q;
  logic       unused_bus;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_q <= '0;
    else     rd_q <= smp.rs ? ddram[ac_q] : {state_q == ST_BUSY, ac_q};
  end

  assign data_out   = rd_q;
  assign data_oe    = e_sync & smp.rw;
  assign unused_bus = bus_rise;
`else
  logic unused_bus;

  assign data_out   = '0;
  assign data_oe    = 1'b0;
  assign unused_bus = ^{bus_rise, e_sync, rd_stb};
`endif

  assign busy      = (state_q == ST_BUSY);
  assign ac        = ac_q;
  assign shift_ofs = ofs_q;
  assign disp_on   = flg_q.disp_on;
  assign cursor_on = flg_q.cursor_on;
  assign blink_on  = flg_q.blink_on;
  assign dl_8bit   = flg_q.dl_8bit;
  assign n_2line   = flg_q.n_2line;
  assign f_5x10    = flg_q.f_5x10;
  assign inc       = flg_q.inc;
  assign shift_en  = flg_q.shift_en;
  assign cg_sel    = flg_q.cg_sel;
  assign cmd_drop  = drop_q;

endmodule
